// File: rtl/clk_div_pkg.sv
// rtl/clk_div_pkg.sv - shared types and constants for the clock divider
package clk_div_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } div_state_t;

   localparam int unsigned MIN_PERIOD_DFLT = 2;

endpackage

// File: rtl/clk_div_ctrl_if.sv
// rtl/clk_div_ctrl_if.sv - period configuration handshake bundle
interface clk_div_ctrl_if #(
   parameter int unsigned CNT_W = 32
) ();

   logic             cfg_valid;
   logic [CNT_W-1:0] cfg_period;
   logic             cfg_ready;
   logic             cfg_err;

   modport master (
      output cfg_valid,
      output cfg_period,
      input  cfg_ready,
      input  cfg_err
   );

   modport slave (
      input  cfg_valid,
      input  cfg_period,
      output cfg_ready,
      output cfg_err
   );

endinterface

// File: rtl/div_counter.sv
// rtl/div_counter.sv - period counter, wrap detect and square-wave register
module div_counter #(
   parameter int unsigned CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             counting_i,
   input  logic             keep_i,
   input  logic [CNT_W-1:0] period_i,
   input  logic [CNT_W-1:0] period_nxt_i,
   output logic             wrap_o,
   output logic             div_out_o
);

   logic [CNT_W-1:0] count_q, count_d;
   logic             div_q;

   assign wrap_o    = counting_i && (count_q == (period_i - CNT_W'(1)));
   assign div_out_o = div_q;

   always_comb begin
      count_d = count_q + CNT_W'(1);
      if (!counting_i || wrap_o) begin
         count_d = '0;
      end
   end

   // div_out is compared against the next count and next period so it lines up with count
   always_ff @(posedge clk) begin
      if (rst) begin
         count_q <= '0;
         div_q   <= 1'b0;
      end else begin
         count_q <= keep_i ? count_d : '0;
         div_q   <= keep_i && (count_d >= (period_nxt_i >> 1));
      end
   end

endmodule

// File: rtl/clk_div_ctrl.sv
// rtl/clk_div_ctrl.sv - run-controlled divider with glitch-free period reload
module clk_div_ctrl
   import clk_div_pkg::*;
#(
   parameter int unsigned CNT_W          = 32,
   parameter int unsigned DEFAULT_PERIOD = 20000000,
   parameter int unsigned MIN_PERIOD     = MIN_PERIOD_DFLT
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             stop,
   clk_div_ctrl_if.slave    cfg,
   output logic             div_out,
   output logic             tick,
   output logic             running,
   output logic [CNT_W-1:0] period_cur
);

   div_state_t       state_q;
   logic [CNT_W-1:0] period_q, period_d;
   logic [CNT_W-1:0] pend_q;
   logic             rdy_q, err_q, tick_q, run_q, run_d;
   logic             wrap, accept, bad, start_only;

   assign start_only = start & ~stop;
   assign accept     = cfg.cfg_valid & rdy_q;
   assign bad        = cfg.cfg_period < CNT_W'(MIN_PERIOD);

   always_comb begin
      period_d = period_q;
      if (accept && !bad && state_q == IDLE) begin
         period_d = cfg.cfg_period;
      end else if (wrap && !rdy_q) begin
         period_d = pend_q;
      end
      run_d = 1'b0;
      case (state_q)
         IDLE:    run_d = start_only;
         RUN:     run_d = !(stop && wrap);
         DRAIN:   run_d = start_only || !wrap;
         default: run_d = 1'b0;
      endcase
   end

   div_counter #(.CNT_W(CNT_W)) u_counter (
      .clk          (clk),
      .rst          (rst),
      .counting_i   (state_q != IDLE),
      .keep_i       (run_d),
      .period_i     (period_q),
      .period_nxt_i (period_d),
      .wrap_o       (wrap),
      .div_out_o    (div_out)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         period_q <= CNT_W'(DEFAULT_PERIOD);
         pend_q   <= '0;
         rdy_q    <= 1'b1;
         err_q    <= 1'b0;
         tick_q   <= 1'b0;
         run_q    <= 1'b0;
      end else begin
         case (state_q)
            IDLE:    if (start_only) state_q <= RUN;
            RUN:     if (stop) state_q <= run_d ? DRAIN : IDLE;
            DRAIN: begin
               if (start_only)  state_q <= RUN;
               else if (wrap)   state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
         period_q <= period_d;
         run_q    <= run_d;
         tick_q   <= wrap;
         err_q    <= accept && bad;
         // An offer landing on a wrap is held for the following wrap
         if (accept && !bad && state_q != IDLE) begin
            pend_q <= cfg.cfg_period;
            rdy_q  <= 1'b0;
         end else if (wrap) begin
            rdy_q  <= 1'b1;
         end
      end
   end

   assign cfg.cfg_ready = rdy_q;
   assign cfg.cfg_err   = err_q;
   assign tick          = tick_q;
   assign running       = run_q;
   assign period_cur    = period_q;

endmodule

// File: tb/tb_clk_div_ctrl.sv
// tb/tb_clk_div_ctrl.sv - table-driven self-checking bench for clk_div_ctrl
module tb_clk_div_ctrl;

   localparam logic [31:0] DEF = 32'd20000000;

   typedef struct {
      logic        rst, start, stop, cv;
      logic [31:0] cp;
      logic        div, tick, run, rdy, err;
      logic [31:0] per;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst, start, stop;
   logic        div_out, tick, running;
   logic [31:0] period_cur;
   int          errors = 0;
   int          checks = 0;
   int          step_no = 0;
   vec_t        tbl[$];
   vec_t        sb[$];

   clk_div_ctrl_if #(.CNT_W(32)) cfg_if ();

   clk_div_ctrl dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .stop       (stop),
      .cfg        (cfg_if.slave),
      .div_out    (div_out),
      .tick       (tick),
      .running    (running),
      .period_cur (period_cur)
   );

   always #5 clk = ~clk;

   function automatic vec_t mk(input logic r, s, p, v, input logic [31:0] c,
                               input logic d, t, n, y, e, input logic [31:0] pr);
      vec_t x;
      x.rst = r; x.start = s; x.stop = p; x.cv = v; x.cp = c;
      x.div = d; x.tick = t; x.run = n; x.rdy = y; x.err = e; x.per = pr;
      return x;
   endfunction

   function automatic void add(input logic r, s, p, v, input logic [31:0] c,
                               input logic d, t, n, y, e, input logic [31:0] pr);
      tbl.push_back(mk(r, s, p, v, c, d, t, n, y, e, pr));
   endfunction

   function automatic void nop(input logic d, t, n, y, input logic [31:0] pr);
      tbl.push_back(mk(0, 0, 0, 0, 0, d, t, n, y, 0, pr));
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s step %0d: got %0h expected %0h", name, step_no, act, exp);
      end
   endtask

   task automatic apply(input vec_t x);
      vec_t e;
      rst              = x.rst;
      start            = x.start;
      stop             = x.stop;
      cfg_if.cfg_valid = x.cv;
      cfg_if.cfg_period = x.cp;
      sb.push_back(x);
      @(posedge clk);
      @(negedge clk);
      e = sb.pop_front();
      chk("div_out",    {31'd0, div_out},          {31'd0, e.div});
      chk("tick",       {31'd0, tick},             {31'd0, e.tick});
      chk("running",    {31'd0, running},          {31'd0, e.run});
      chk("cfg_ready",  {31'd0, cfg_if.cfg_ready}, {31'd0, e.rdy});
      chk("cfg_err",    {31'd0, cfg_if.cfg_err},   {31'd0, e.err});
      chk("period_cur", period_cur,                e.per);
      step_no++;
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; stop = 1'b0;
      cfg_if.cfg_valid = 1'b0; cfg_if.cfg_period = '0;

      // reset, P=4 configured in IDLE, start, two periods
      add(1,0,0,0,0, 0,0,0,1,0,DEF);
      add(1,0,0,0,0, 0,0,0,1,0,DEF);
      add(0,0,0,1,4, 0,0,0,1,0,4);
      add(0,1,0,0,0, 0,0,1,1,0,4);
      nop(0,0,1,1,4); nop(1,0,1,1,4); nop(1,0,1,1,4); nop(0,1,1,1,4);
      nop(0,0,1,1,4); nop(1,0,1,1,4); nop(1,0,1,1,4); nop(0,1,1,1,4);
      // offer 6 at count 1, applied at the next wrap
      nop(0,0,1,1,4);
      add(0,0,0,1,6, 1,0,1,0,0,4);
      nop(1,0,1,0,4); nop(0,1,1,1,6);
      nop(0,0,1,1,6); nop(0,0,1,1,6); nop(1,0,1,1,6); nop(1,0,1,1,6); nop(1,0,1,1,6);
      nop(0,1,1,1,6);
      // too-small offer discarded, then switch to P=5
      add(0,0,0,1,1, 0,0,1,1,1,6);
      nop(0,0,1,1,6);
      add(0,0,0,1,5, 1,0,1,0,0,6);
      nop(1,0,1,0,6); nop(1,0,1,0,6); nop(0,1,1,1,5);
      nop(0,0,1,1,5); nop(1,0,1,1,5); nop(1,0,1,1,5); nop(1,0,1,1,5); nop(0,1,1,1,5);
      add(0,0,0,1,8, 0,0,1,0,0,5);
      nop(1,0,1,0,5); nop(1,0,1,0,5); nop(1,0,1,0,5); nop(0,1,1,1,8);
      // P=8, stop at count 2 drains the period
      nop(0,0,1,1,8); nop(0,0,1,1,8);
      add(0,0,1,0,0, 0,0,1,1,0,8);
      nop(1,0,1,1,8); nop(1,0,1,1,8); nop(1,0,1,1,8); nop(1,0,1,1,8);
      nop(0,1,0,1,8); nop(0,0,0,1,8);
      // IDLE ignores stop and start+stop; bad offer in IDLE
      add(0,0,1,0,0, 0,0,0,1,0,8);
      add(0,1,1,0,0, 0,0,0,1,0,8);
      add(0,0,0,1,0, 0,0,0,1,1,8);
      nop(0,0,0,1,8);
      // start at count 5 of DRAIN keeps the period going; stop at count 7 ends at that wrap
      add(0,1,0,0,0, 0,0,1,1,0,8);
      nop(0,0,1,1,8); nop(0,0,1,1,8);
      add(0,0,1,0,0, 0,0,1,1,0,8);
      nop(1,0,1,1,8); nop(1,0,1,1,8);
      add(0,1,0,0,0, 1,0,1,1,0,8);
      nop(1,0,1,1,8); nop(0,1,1,1,8);
      nop(0,0,1,1,8); nop(0,0,1,1,8); nop(0,0,1,1,8);
      nop(1,0,1,1,8); nop(1,0,1,1,8); nop(1,0,1,1,8); nop(1,0,1,1,8);
      add(0,0,1,0,0, 0,1,0,1,0,8);
      nop(0,0,0,1,8);
      // reset at count 3 with 10 pending
      add(0,1,0,0,0, 0,0,1,1,0,8);
      nop(0,0,1,1,8);
      add(0,0,0,1,10, 0,0,1,0,0,8);
      nop(0,0,1,0,8);
      add(1,0,0,0,0, 0,0,0,1,0,DEF);
      for (int i = 0; i < 10; i++) nop(0,0,0,1,DEF);

      @(negedge clk);
      for (int i = 0; i < tbl.size(); i++) apply(tbl[i]);

      // odd period with an update pending when DRAIN wraps to IDLE
      apply(mk(0,0,0,1,3, 0,0,0,1,0,3));
      apply(mk(0,1,0,0,0, 0,0,1,1,0,3));
      apply(mk(0,0,0,0,0, 1,0,1,1,0,3));
      apply(mk(0,0,1,1,2, 1,0,1,0,0,3));
      apply(mk(0,0,0,0,0, 0,1,0,1,0,2));
      for (int i = 0; i < 3; i++) apply(mk(0,0,0,0,0, 0,0,0,1,0,2));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

endmodule

// File: doc/clk_div_ctrl.md
# clk_div_ctrl

Run-controlled, reconfigurable clock divider. Produces a divided square wave and a one-cycle period tick from `clk`. Accepts new period values over a valid/ready handshake and applies them only at a period boundary, so the output never glitches. Start/stop control drains the current period before halting. It sits between the system control/register logic and every consumer of slow enables (LED blink, sample pacing, timeouts).

## Interface
- `CNT_W`, 32, width of the period counter and of `cfg_period`
- `DEFAULT_PERIOD`, 20000000, period loaded at reset (must fit in `CNT_W` and be ≥ `MIN_PERIOD`)
- `MIN_PERIOD`, 2, smallest accepted period
- `clk`  in  1  sole clock
- `rst`  in  1  synchronous, active-high reset
- `start`  in  1  pulse; begin or continue running
- `stop`  in  1  pulse; finish the current period, then halt
- `cfg_valid`  in  1  new period offered
- `cfg_period`  in  CNT_W  offered period, in `clk` cycles
- `cfg_ready`  out  1  no update pending; offer is accepted when `cfg_valid & cfg_ready`
- `cfg_err`  out  1  one-cycle pulse: the accepted offer was below `MIN_PERIOD` and was discarded
- `div_out`  out  1  divided square wave
- `tick`  out  1  one-cycle pulse per completed period
- `running`  out  1  high in RUN and DRAIN
- `period_cur`  out  CNT_W  period currently in effect

## Operation
- States: IDLE, RUN, DRAIN.
- IDLE:
  - `count` = 0, `div_out` = 0.
  - `start` → RUN.
  - `stop` is ignored. `start` and `stop` together are ignored.
- RUN:
  - `count` increments and wraps from `period_cur-1` to 0.
  - `stop`, or `start` and `stop` together, → DRAIN.
- DRAIN:
  - Counting continues as in RUN.
  - At the wrap: `count` = 0, `div_out` = 0, `tick` fires, → IDLE.
  - `start` without `stop` → RUN, with no discontinuity in `count`.
- `div_out` is high exactly when `count ≥ period_cur>>1`. Low time is floor(P/2) cycles; high time is P − floor(P/2) cycles.
- `tick` fires on every wrap in RUN and DRAIN. It does not fire on `start`.
- Config handshake:
  - If the accepted value is below `MIN_PERIOD`, it is discarded and `cfg_err` pulses.
  - In IDLE, a valid value is written to `period_cur` directly, and `cfg_ready` stays high.
  - In RUN or DRAIN, a valid value is latched as pending and `cfg_ready` drops. At the next wrap, `period_cur` takes the pending value, the new period starts from `count` = 0, and `cfg_ready` rises.
  - An offer accepted in the same cycle as a wrap is applied at the following wrap, not the current one.
  - If DRAIN wraps to IDLE with a pending value, it is applied at that wrap.
- Arithmetic: `count` and its compares are unsigned, `CNT_W` bits. The half value is recomputed from `period_cur`.

## Timing
- All outputs are registered.
- Reset values:
  - IDLE, `count` = 0, `div_out` = 0, `tick` = 0
  - `cfg_ready` = 1, `cfg_err` = 0, `running` = 0
  - `period_cur` = `DEFAULT_PERIOD`
  - pending value cleared
- Reset mid-operation discards any pending update. Reset has priority over every other input.
- `start` sampled at edge N: `running` = 1 and `count` = 0 from N+1. `div_out` first rises at N+1+floor(P/2).
- `tick` is high during the cycle in which `count` is 0 after a wrap.
- Accept at edge N:
  - In IDLE, `period_cur` is updated at N+1.
  - In RUN, `cfg_ready` = 0 at N+1.
  - `cfg_err` is high at N+1 only.
- A `stop` during the last cycle of a period (`count` = P−1) leaves DRAIN at that same wrap. `running` = 0 on the next cycle.

## Structure
- Package `clk_div_pkg` holds:
  - the state enum `div_state_t` (IDLE/RUN/DRAIN)
  - the `MIN_PERIOD` default constant
- Sub-module `div_counter` holds the datapath:
  - `count` register and wrap detect
  - half compare and `div_out` register
- `clk_div_ctrl` holds the FSM, handshake, pending register and `tick`/`cfg_err` generation.

## Test plan
- Reset, configure P=4 in IDLE, `start` → `div_out` sequence 0,0,1,1 repeating; `tick` every 4 cycles, first at cycle 4 after start; `period_cur` = 4.
- P=5 running → `div_out` low 2 cycles, high 3 cycles; `tick` every 5 cycles.
- Running at P=4, offer 6 at `count` = 1 → `cfg_ready` 0 next cycle; current period completes at 4; the next period is 6 cycles (low 3, high 3); `cfg_ready` returns to 1 at that wrap.
- Offer `cfg_period` = 1 → `cfg_err` pulses once; `period_cur` unchanged; `cfg_ready` stays 1.
- P=8, `stop` at `count` = 2 → 5 more cycles counted, `tick`, then `running` = 0 and `div_out` = 0. Repeat with `start` at `count` = 5 of DRAIN → stays running, period uninterrupted.
- Running P=8 with 10 pending, assert `rst` at `count` = 3 → next cycle all outputs at reset values, `period_cur` = `DEFAULT_PERIOD`, pending 10 never applied.
